// File: rtl/mma_pkg.sv
// Shared constants, FSM encoding and element index map
// for the 3x3 outer-product accumulator.
package mma_pkg;

  localparam int DATA_W = 4;
  localparam int ACC_W  = 10;
  localparam int MAT_N  = 3;
  localparam int N_ELEM = MAT_N * MAT_N;

  localparam logic [3:0] LAST_IDX = 4'(N_ELEM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC1,
    S_MAC2,
    S_MAC3,
    S_DRAIN,
    S_DONE
  } state_e;

  // Row-major element index -> (row, col)
  localparam int IDX_ROW [N_ELEM] = '{
    0, 0, 0, 1, 1, 1, 2, 2, 2
  };
  localparam int IDX_COL [N_ELEM] = '{
    0, 1, 2, 0, 1, 2, 0, 1, 2
  };

endpackage

// File: rtl/mac_cell.sv
// One accumulator: sync clear, zero-on-start,
// enable-gated unsigned multiply-add.
module mac_cell #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 10
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              zero,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    acc_d;
  logic [ACC_W-1:0]    acc_q;

  always_comb begin
    prod  = a * b;
    acc_d = acc_q;
    if (zero) begin
      acc_d = '0;
    end else if (en) begin
      // Sum wraps modulo 2^ACC_W if ACC_W is undersized
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/outer_product_accumulator.sv
// Sequences the operand bank, accumulates C = W*X as three
// outer products, then streams C row-major over valid/ready.
module outer_product_accumulator #(
  parameter int DATA_W = mma_pkg::DATA_W,
  parameter int ACC_W  = mma_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic [DATA_W-1:0] data_w1,
  input  logic [DATA_W-1:0] data_w2,
  input  logic [DATA_W-1:0] data_w3,
  input  logic [DATA_W-1:0] data_x1,
  input  logic [DATA_W-1:0] data_x2,
  input  logic [DATA_W-1:0] data_x3,
  output logic              unload1,
  output logic              unload2,
  output logic              unload3,
  output logic [ACC_W-1:0]  out_data,
  output logic [3:0]        out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  import mma_pkg::*;

  state_e     state_q;
  state_e     state_d;
  logic       start_d_q;
  logic [3:0] out_idx_q;
  logic [3:0] out_idx_d;
  logic       trigger;
  logic       mac_en;
  logic       fire;

  logic [DATA_W-1:0] w_op [MAT_N];
  logic [DATA_W-1:0] x_op [MAT_N];
  logic [ACC_W-1:0]  acc  [N_ELEM];

  assign w_op[0] = data_w1;
  assign w_op[1] = data_w2;
  assign w_op[2] = data_w3;
  assign x_op[0] = data_x1;
  assign x_op[1] = data_x2;
  assign x_op[2] = data_x3;

  for (genvar e = 0; e < N_ELEM; e++) begin : g_cell
    mac_cell #(
      .DATA_W(DATA_W),
      .ACC_W (ACC_W)
    ) u_cell (
      .clk  (clk),
      .clear(clear),
      .zero (trigger),
      .en   (mac_en),
      .a    (w_op[IDX_ROW[e]]),
      .b    (x_op[IDX_COL[e]]),
      .acc  (acc[e])
    );
  end

  always_comb begin
    unload1   = (state_q == S_MAC1);
    unload2   = (state_q == S_MAC2);
    unload3   = (state_q == S_MAC3);
    mac_en    = unload1 | unload2 | unload3;
    out_valid = (state_q == S_DRAIN);
    done      = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    trigger   = (state_q == S_IDLE) & start & ~start_d_q;
    fire      = out_valid & out_ready;
    out_idx   = out_idx_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (trigger) state_d = S_MAC1;
      S_MAC1:  state_d = S_MAC2;
      S_MAC2:  state_d = S_MAC3;
      S_MAC3:  state_d = S_DRAIN;
      S_DRAIN: begin
        if (fire && out_idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_idx_d = out_idx_q;
    if (state_q != S_DRAIN) begin
      out_idx_d = '0;
    end else if (fire) begin
      out_idx_d = (out_idx_q == LAST_IDX) ? 4'd0
                                          : out_idx_q + 4'd1;
    end
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int e = 0; e < N_ELEM; e++) begin
        if (out_idx_q == 4'(e)) out_data = acc[e];
      end
    end
  end

  always_ff @(posedge clk) begin
    start_d_q <= start;
    if (clear) begin
      state_q   <= S_IDLE;
      out_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      out_idx_q <= out_idx_d;
    end
  end

endmodule

// File: tb/tb_outer_product_accumulator.sv
// Directed + randomized bench for outer_product_accumulator
// with an operand-bank model and a matrix-product reference.
module tb_outer_product_accumulator;

  logic       clk = 1'b0;
  logic       clear;
  logic       start;
  logic [3:0] data_w1, data_w2, data_w3;
  logic [3:0] data_x1, data_x2, data_x3;
  logic       unload1, unload2, unload3;
  logic [9:0] out_data;
  logic [3:0] out_idx;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  int W [3][3];
  int X [3][3];
  int junk;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  outer_product_accumulator dut (
    .clk      (clk),
    .clear    (clear),
    .start    (start),
    .data_w1  (data_w1),
    .data_w2  (data_w2),
    .data_w3  (data_w3),
    .data_x1  (data_x1),
    .data_x2  (data_x2),
    .data_x3  (data_x3),
    .unload1  (unload1),
    .unload2  (unload2),
    .unload3  (unload3),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  // Operand bank: column k of W and row k of X on strobe k
  always_comb begin
    int k;
    k = -1;
    if (unload1) k = 0;
    else if (unload2) k = 1;
    else if (unload3) k = 2;
    data_w1 = 4'(junk);
    data_w2 = 4'(junk >> 4);
    data_w3 = 4'(junk >> 8);
    data_x1 = 4'(junk >> 12);
    data_x2 = 4'(junk >> 16);
    data_x3 = 4'(junk >> 20);
    if (k >= 0) begin
      data_w1 = 4'(W[0][k]);
      data_w2 = 4'(W[1][k]);
      data_w3 = 4'(W[2][k]);
      data_x1 = 4'(X[k][0]);
      data_x2 = 4'(X[k][1]);
      data_x3 = 4'(X[k][2]);
    end
  end

  function automatic int ref_c(input int e);
    int s;
    s = 0;
    for (int k = 0; k < 3; k++) s += W[e / 3][k] * X[k][e % 3];
    return s % 1024;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input int exp);
    n_cmp++;
    assert (obs === 32'(exp)) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_mats(input int wv[9], input int xv[9]);
    for (int e = 0; e < 9; e++) begin
      W[e / 3][e % 3] = wv[e];
      X[e / 3][e % 3] = xv[e];
    end
  endtask

  task automatic rand_mats();
    for (int e = 0; e < 9; e++) begin
      W[e / 3][e % 3] = int'($urandom_range(0, 15));
      X[e / 3][e % 3] = int'($urandom_range(0, 15));
    end
    junk = int'($urandom);
  endtask

  task automatic do_run(input int stall_e,
                        input int stall_n,
                        input bit tog);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("unload", 32'({unload3, unload2, unload1}), 1 << k);
      chk("mac_busy", 32'(busy), 1);
      chk("mac_valid", 32'(out_valid), 0);
    end
    for (int e = 0; e < 9; e++) begin
      @(negedge clk);
      if (tog && e == 2) start = 1'b0;
      if (tog && e == 3) start = 1'b1;
      chk("valid", 32'(out_valid), 1);
      chk("idx", 32'(out_idx), e);
      chk("data", 32'(out_data), ref_c(e));
      chk("early_done", 32'(done), 0);
      if (e == stall_e) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          chk("bp_idx", 32'(out_idx), e);
          chk("bp_data", 32'(out_data), ref_c(e));
          chk("bp_valid", 32'(out_valid), 1);
          chk("bp_done", 32'(done), 0);
        end
        out_ready = 1'b1;
      end
    end
    @(negedge clk);
    chk("done", 32'(done), 1);
    chk("done_valid", 32'(out_valid), 0);
    chk("done_busy", 32'(busy), 1);
    @(negedge clk);
    chk("post_done", 32'(done), 0);
    chk("post_busy", 32'(busy), 0);
  endtask

  initial begin
    clear     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    junk      = int'($urandom);
    for (int e = 0; e < 9; e++) begin
      W[e / 3][e % 3] = 0;
      X[e / 3][e % 3] = 0;
    end
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_idx", 32'(out_idx), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_unload", 32'({unload3, unload2, unload1}), 0);
    clear = 1'b0;

    set_mats('{1, 2, 3, 4, 5, 6, 7, 8, 9},
             '{1, 0, 0, 0, 1, 0, 0, 0, 1});
    do_run(-1, 0, 1'b0);

    set_mats('{1, 2, 3, 4, 5, 6, 7, 8, 9},
             '{9, 8, 7, 6, 5, 4, 3, 2, 1});
    do_run(-1, 0, 1'b0);

    set_mats('{15, 15, 15, 15, 15, 15, 15, 15, 15},
             '{15, 15, 15, 15, 15, 15, 15, 15, 15});
    do_run(-1, 0, 1'b0);
    chk("max_675", 32'(ref_c(8)), 675);

    set_mats('{1, 2, 3, 4, 5, 6, 7, 8, 9},
             '{9, 8, 7, 6, 5, 4, 3, 2, 1});
    do_run(4, 3, 1'b0);

    for (int r = 0; r < 4; r++) begin
      rand_mats();
      do_run(int'($urandom_range(0, 8)),
             int'($urandom_range(1, 4)), 1'b0);
    end

    rand_mats();
    do_run(-1, 0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("no_retrig", 32'(busy), 0);
    end

    rand_mats();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("pre_clr_mac1", 32'(unload1), 1);
    @(negedge clk);
    chk("pre_clr_mac2", 32'(unload2), 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_busy", 32'(busy), 0);
    chk("clr_unload", 32'({unload3, unload2, unload1}), 0);
    chk("clr_valid", 32'(out_valid), 0);
    repeat (3) begin
      @(negedge clk);
      chk("clr_no_retrig", 32'(busy), 0);
    end
    rand_mats();
    do_run(-1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/outer_product_accumulator.md
Name: outer_product_accumulator

Overview:
- Sits directly downstream of the 3x3 operand memory bank.
- Sequences the bank's unload1/unload2/unload3 strobes and consumes the three W-column and three X-row nibbles presented on each strobe.
- Accumulates C = W*X as three outer-product steps in nine accumulators, then drains the result row-major over a valid/ready stream.

Parameters:
- DATA_W, 4, operand width (unsigned); must match the memory bank nibble width.
- ACC_W, 10, accumulator/result width; 2*DATA_W+2 holds 3*15*15=675 without overflow.

Ports:
- clk  input  1  single clock, rising edge.
- clear  input  1  synchronous active-high reset.
- start  input  1  level from memory bank, high once X is loaded; run triggers on its rising edge.
- data_w1, data_w2, data_w3  input  DATA_W each  W column k: W[0][k], W[1][k], W[2][k].
- data_x1, data_x2, data_x3  input  DATA_W each  X row k: X[k][0], X[k][1], X[k][2].
- unload1, unload2, unload3  output  1 each  one-hot step-k select to the memory bank.
- out_data  output  ACC_W  current result element.
- out_idx  output  4  element index 0..8, row-major (idx = 3*i+j).
- out_valid  output  1  out_data/out_idx valid.
- out_ready  input  1  consumer accepts the element.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last element is accepted.

Behaviour:
- Reset (clear=1 at an edge):
  - state=IDLE; all accumulators=0; unload*=0; out_valid=0; out_idx=0; out_data=0; busy=0; done=0.
  - start_d <= start, so a start level already high does not retrigger after reset.
  - clear overrides everything, including mid-MAC or mid-DRAIN; the partial run is discarded.
- Start detection:
  - start_d registers start every cycle.
  - Trigger = start & ~start_d, evaluated only in IDLE; ignored in all other states.
- FSM states: IDLE, MAC1, MAC2, MAC3, DRAIN, DONE.
  - IDLE -> MAC1 on trigger; the same edge zeroes all nine accumulators.
  - MAC1 -> MAC2 -> MAC3 -> DRAIN, unconditionally, one cycle each.
  - DRAIN -> DONE when out_valid & out_ready & out_idx==8.
  - DONE -> IDLE after one cycle.
- MACk (k=1..3):
  - unloadk=1 (registered/decoded from state, glitch-free), other strobes 0.
  - Bank outputs are combinational from the strobe, so data is sampled at the closing edge of the same cycle.
  - acc[i][j] <= acc[i][j] + data_w(i+1)*data_x(j+1) for i,j in 0..2.
  - Products are unsigned 2*DATA_W bits, zero-extended to ACC_W; if ACC_W is undersized the sum wraps modulo 2^ACC_W.
- DRAIN:
  - out_valid=1; out_data=acc[out_idx/3][out_idx%3], combinational from out_idx.
  - out_idx increments only on out_valid & out_ready; it holds under backpressure with out_data stable.
  - out_idx returns to 0 on leaving DRAIN.
- DONE: done=1 for exactly one cycle; out_valid=0. Accumulators keep their values until the next trigger.
- Latency with out_ready tied high, trigger seen in cycle 0:
  - MAC1..MAC3 in cycles 1..3.
  - Elements 0..8 in cycles 4..12.
  - done in cycle 13; IDLE in cycle 14.
- Inputs data_* are don't-care outside MAC states.

Decomposition:
- Package mma_pkg:
  - DATA_W, ACC_W, MAT_N=3.
  - State typedef/encodings: IDLE, MAC1, MAC2, MAC3, DRAIN, DONE.
  - Index-to-(row,col) constants.
- Sub-module mac_cell, instantiated 9x: one accumulator register with synchronous clear, zero-on-start, and enable-gated multiply-add of two DATA_W operands.
- FSM, strobe decode and drain mux live in the top.

Test Plan:
- Identity:
  - Stimulus: W=[[1,2,3],[4,5,6],[7,8,9]], X=I, start 0->1, out_ready=1.
  - Response: unload1/2/3 in cycles 1/2/3; out_data 1..9 with out_idx 0..8 in cycles 4..12; done pulse in cycle 13.
- General product:
  - Stimulus: W=[[1,2,3],[4,5,6],[7,8,9]], X=[[9,8,7],[6,5,4],[3,2,1]].
  - Response: stream 30,24,18,84,69,54,138,114,90.
- Max operands:
  - Stimulus: all W and X entries = 15.
  - Response: all nine outputs = 675, no wrap.
- Backpressure:
  - Stimulus: out_ready low for 3 cycles while out_idx=4.
  - Response: out_idx=4 and out_data hold stable; stream resumes with idx 5; done only after idx 8 is accepted.
- Reset mid-run:
  - Stimulus: assert clear during MAC2 with start still high.
  - Response: next cycle IDLE, unload*=0, busy=0, no retrigger. A later start 0->1 reruns and gives correct results, no stale partial sums.
- Retrigger rules:
  - Stimulus: start held high after done; start toggled 1->0->1 during DRAIN.
  - Response: no new run in either case. A fresh 0->1 while in IDLE starts a run that re-zeroes the accumulators.
